// File: rtl/jk_bank_sequencer.sv
// Sequencer for a bank of JK cells: latches a job, loads the bank, then steps it
// (up/down/shift/toggle) until it matches the terminal value or the cycle limit expires.
module jk_bank_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MAX_CYC = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] CYC_LIMIT = 8'(MAX_CYC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cyc_q, cyc_d;
  logic             timeout_q, timeout_d;

  logic [WIDTH-1:0] drv_j, drv_k;
  logic [WIDTH-1:0] j_cmb, k_cmb;
  logic [WIDTH-1:0] shl;
  logic             up_c, dn_c;

  // Per-mode J/K drive derived from the current bank; only applied in RUN.
  always_comb begin
    drv_j = '0;
    drv_k = '0;
    up_c  = 1'b1;
    dn_c  = 1'b1;
    shl   = {q_q[WIDTH-2:0], 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode_q)
        2'b00: begin
          drv_j[i] = up_c;
          drv_k[i] = up_c;
        end
        2'b01: begin
          drv_j[i] = dn_c;
          drv_k[i] = dn_c;
        end
        2'b10: begin
          drv_j[i] = shl[i];
          drv_k[i] = ~shl[i];
        end
        default: begin
          drv_j[i] = 1'b1;
          drv_k[i] = 1'b1;
        end
      endcase
      up_c = up_c & q_q[i];
      dn_c = dn_c & ~q_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    term_d    = term_q;
    mode_d    = mode_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    j_cmb     = '0;
    k_cmb     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_d    = load_val;
          term_d    = term_val;
          mode_d    = mode;
          cyc_d     = '0;
          timeout_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          j_cmb   = load_q;
          k_cmb   = ~load_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (q_q == term_q) begin
          state_d = S_DONE;
        end else if (cyc_q == CYC_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          j_cmb = drv_j;
          k_cmb = drv_k;
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Standard JK cell update: hold, clear, set, toggle.
  always_comb begin
    q_d = (j_cmb & ~q_q) | (~k_cmb & q_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      load_q    <= '0;
      term_q    <= '0;
      mode_q    <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      load_q    <= load_d;
      term_q    <= term_d;
      mode_q    <= mode_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  assign q       = q_q;
  assign j_out   = j_cmb;
  assign k_out   = k_cmb;
  assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign timeout = timeout_q;

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Controller for a bank of WIDTH JK flip-flop cells that lives inside this block.
- On a start request it latches a job: load value, terminal value and mode.
- It loads the bank through J/K, then drives J/K every cycle to count up, count down, shift or toggle the bank until the bank equals the terminal value or a cycle limit expires.
- It is the sequencing layer for the JK register cells used in the lab designs.

Parameters:
- WIDTH, 4, number of JK cells in the bank.
- MAX_CYC, 20, maximum number of RUN cycles before timeout (1 to 255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  cancels the active job in LOAD or RUN.
- mode  input  2  00 count up, 01 count down, 10 shift left (serial-in 0), 11 toggle all.
- load_val  input  WIDTH  initial bank value.
- term_val  input  WIDTH  terminal bank value.
- q  output  WIDTH  current bank state.
- j_out  output  WIDTH  J drive currently applied to the cells.
- k_out  output  WIDTH  K drive currently applied to the cells.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse in DONE.
- timeout  output  1  set when a job ends on the cycle limit; sticky until the next accepted start.

Behaviour:
- Interface: one clock (clk). Reset (reset) is asynchronous and active-high.
- Reset: state IDLE, q=0, cycle count=0, latched job=0, timeout=0, busy=0, done=0, j_out=k_out=0.
- Cells: standard JK behaviour on each rising edge, per bit.
  - J=0, K=0: hold.
  - J=0, K=1: clear.
  - J=1, K=0: set.
  - J=1, K=1: toggle.
- j_out and k_out are combinational from state, q and the latched job.
- State machine (registered), IDLE -> LOAD -> RUN -> DONE -> IDLE.
  - IDLE: J=K=0. If start=1, latch mode, load_val and term_val, clear timeout and the cycle count, go to LOAD.
  - LOAD (exactly 1 cycle): J=load_r, K=~load_r. Next: RUN, with q=load_r.
  - RUN, evaluated in this priority order:
    1. abort: J=K=0, go to IDLE with no done pulse.
    2. q==term_r: J=K=0, go to DONE.
    3. cycle count==MAX_CYC: J=K=0, set timeout, go to DONE.
    4. Otherwise apply the mode drive and increment the cycle count.
  - DONE (exactly 1 cycle): done=1, J=K=0. Next: IDLE.
- Mode drive in RUN:
  - Up: bit0 J=K=1; bit i J=K=&q[i-1:0]. Wraps all-ones to 0.
  - Down: bit0 J=K=1; bit i J=K=&~q[i-1:0]. Wraps 0 to all-ones.
  - Shift: bit i J=q[i-1], K=~q[i-1]; bit0 J=0, K=1.
  - Toggle: J=K=all ones.
- Latency for a job needing n steps:
  - LOAD = 1 cycle, RUN = n+1 cycles, then DONE.
  - done rises n+2 cycles after the cycle in which start was accepted.
  - If load_val==term_val: n=0 and RUN lasts 1 cycle.
- start is ignored outside IDLE, including in DONE.
- abort is ignored in IDLE and DONE.
- abort in LOAD: returns to IDLE; q is not loaded.
- Mode and input values changing mid-job have no effect; the latched copies are used.
- reset mid-job: immediate return to reset values, independent of clk.
- Timeout: q holds its last value; done still pulses.

Test Plan:
All scenarios use WIDTH=4, MAX_CYC=20.
1. Count up, start with mode=00, load=3, term=7 -> q sequence 3,4,5,6,7; busy for 6 cycles; done 1 cycle; timeout=0. Then load=14, term=1 -> q 14,15,0,1 (wrap).
2. Count down, mode=01, load=2, term=13 -> q 2,1,0,15,14,13; done pulse; timeout=0.
3. Shift, mode=10, load=4'b1011, term=0 -> q 1011,0110,1100,1000,0000; the j_out/k_out bit0 pair is 0/1 in every RUN drive cycle.
4. Toggle timeout, mode=11, load=4'b0101, term=4'b0011 -> q alternates 0101/1010 for 20 RUN cycles; then done=1 and timeout=1; q holds; timeout clears on the next accepted start.
5. Control hazards:
   - start pulsed while busy -> ignored; the job in flight finishes unchanged.
   - abort in the 3rd RUN cycle of an up job from 0 -> IDLE; q held at 2; no done pulse.
   - start in DONE -> ignored.
6. Async reset mid-RUN of a down job -> q=0, busy=0, j_out=k_out=0 immediately (before the next clk edge). After release, start with load=term=9 -> done 2 cycles after acceptance; q=9.
